// File: rtl/wb_demux3_if.sv
// Bus bundle for wb_demux3: one producer-side handshake and a three-way
// one-hot consumer side that shares a single data bus.
interface wb_demux3_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/wb_demux3.sv
// One-source, three-destination demultiplexer with an in-order circular
// buffer; illegal selects are dropped and counted.
module wb_demux3 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic         clk,
    input  logic         reset,
    wb_demux3_if.slave   bus,
    output logic [7:0]   drop_cnt,
    output logic [2:0]   level
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            2'b00:   oh = 3'b001;
            2'b01:   oh = 3'b010;
            2'b10:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    logic [1:0]        sel_mem_r  [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [2:0]        level_r;
    logic [7:0]        drop_cnt_r;
    logic [2:0]        out_valid_r;
    logic [DATA_W-1:0] out_data_r;

    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [2:0]        level_nxt_s;
    logic [7:0]        drop_cnt_nxt_s;
    logic [2:0]        out_valid_nxt_s;
    logic [DATA_W-1:0] out_data_nxt_s;

    logic              in_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic [1:0]        head_sel_s;
    logic [DATA_W-1:0] head_data_s;

    // Ready depends only on stored occupancy; reset forces it low.
    assign in_ready_s    = (level_r < DEPTH_L) && !reset;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign drop_cnt      = drop_cnt_r;
    assign level         = level_r;

    // Transfer qualification on both sides of the buffer.
    always_comb begin
        accept_s = bus.in_valid && in_ready_s;
        push_s   = accept_s && (bus.in_sel != 2'b11);
        drop_s   = accept_s && (bus.in_sel == 2'b11);
        pop_s    = |(out_valid_r & bus.out_ready);
    end

    // Pointer, occupancy and drop-counter next state.
    always_comb begin
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + 3'd1;
            2'b01:   level_nxt_s = level_r - 3'd1;
            default: level_nxt_s = level_r;
        endcase

        if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_nxt_s = drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Next head word: the slot being written this cycle is not yet in
    // storage, so forward the incoming word when it becomes the head.
    always_comb begin
        if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_sel_s  = bus.in_sel;
            head_data_s = bus.in_data;
        end else begin
            head_sel_s  = sel_mem_r[rd_ptr_nxt_s];
            head_data_s = data_mem_r[rd_ptr_nxt_s];
        end

        if (level_nxt_s != 3'd0) begin
            out_valid_nxt_s = sel_onehot(head_sel_s);
            out_data_nxt_s  = head_data_s;
        end else begin
            out_valid_nxt_s = 3'b000;
            out_data_nxt_s  = out_data_r;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= 3'd0;
            drop_cnt_r  <= 8'd0;
            out_valid_r <= 3'b000;
            out_data_r  <= '0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    // Buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            sel_mem_r[wr_ptr_r]  <= bus.in_sel;
            data_mem_r[wr_ptr_r] <= bus.in_data;
        end else begin
            sel_mem_r[wr_ptr_r]  <= sel_mem_r[wr_ptr_r];
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_wb_demux3.sv
// Directed bench for wb_demux3 with a queue-based reference model compared
// every cycle, plus literal spot checks of key scenarios.
module tb_wb_demux3;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] drop_cnt;
    logic [2:0] level;

    wb_demux3_if #(.DATA_W(DATA_W)) bus ();

    wb_demux3 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain FIFO of {sel,data} plus counters.
    logic [33:0] mq[$];
    int          m_drop = 0;
    logic [31:0] m_last = 32'h0;
    logic        check_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_drop = 0;
            m_last = 32'h0;
        end else begin
            logic did_pop;
            logic did_acc;
            did_pop = (mq.size() > 0) && bus.out_ready[mq[0][33:32]];
            did_acc = bus.in_valid && (mq.size() < DEPTH);
            if (did_pop) void'(mq.pop_front());
            if (did_acc) begin
                if (bus.in_sel == 2'b11) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq.push_back({bus.in_sel, bus.in_data});
                end
            end
            if (mq.size() > 0) m_last = mq[0][31:0];
        end
    end

    logic [34:0] emerged[$];
    logic        log_en = 1'b0;

    // Per-cycle comparison of DUT against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            logic [2:0]  ev;
            logic [31:0] ed;
            ev = (mq.size() > 0) ? (3'b001 << mq[0][33:32]) : 3'b000;
            ed = (mq.size() > 0) ? mq[0][31:0] : m_last;
            chk("in_ready",  64'(bus.in_ready), 64'(!reset && (mq.size() < DEPTH)));
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            chk("out_data",  64'(bus.out_data), 64'(ed));
            chk("level",     64'(level), 64'(mq.size()));
            chk("drop_cnt",  64'(drop_cnt), 64'(m_drop));
        end
        if (log_en && |(bus.out_valid & bus.out_ready))
            emerged.push_back({bus.out_valid, bus.out_data});
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [2:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 3'b000);
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  64'(bus.out_data), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

        // Single word
        drive(1'b1, 2'b01, 32'hDEADBEEF, 3'b111);
        tick();
        chk("single_valid", 64'(bus.out_valid), 64'h2);
        chk("single_data",  64'(bus.out_data), 64'hDEADBEEF);
        chk("single_level", 64'(level), 64'd1);
        drive(1'b0, 2'b00, 32'h0, 3'b111);
        tick();
        chk("single_drained", 64'(level), 64'd0);
        chk("single_hold",    64'(bus.out_data), 64'hDEADBEEF);

        // Fill and stall
        drive(1'b1, 2'b00, 32'hAAAA0001, 3'b000);
        tick();
        drive(1'b1, 2'b10, 32'hBBBB0002, 3'b000);
        tick();
        drive(1'b1, 2'b00, 32'hCCCC0003, 3'b000);
        chk("full_level", 64'(level), 64'd2);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 64'(bus.out_valid), 64'h1);
            chk("stall_data",  64'(bus.out_data), 64'hAAAA0001);
        end

        // Drain order with head-of-line blocking
        drive(1'b1, 2'b00, 32'hCCCC0003, 3'b100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hol_level", 64'(level), 64'd2);
            chk("hol_valid", 64'(bus.out_valid), 64'h1);
        end
        drive(1'b1, 2'b00, 32'hCCCC0003, 3'b001);
        tick();
        chk("popA_level", 64'(level), 64'd1);
        chk("popA_valid", 64'(bus.out_valid), 64'h4);
        chk("popA_data",  64'(bus.out_data), 64'hBBBB0002);
        drive(1'b1, 2'b00, 32'hCCCC0003, 3'b000);
        tick();
        chk("acceptC_level", 64'(level), 64'd2);
        drive(1'b0, 2'b00, 32'h0, 3'b111);
        tick();
        chk("popB_valid", 64'(bus.out_valid), 64'h1);
        chk("popB_data",  64'(bus.out_data), 64'hCCCC0003);
        tick();
        chk("drained", 64'(level), 64'd0);

        // Illegal select saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'b11, 32'(i), 3'b111);
            tick();
            if (i == 253) chk("drop_254", 64'(drop_cnt), 64'hFE);
        end
        chk("drop_sat",    64'(drop_cnt), 64'hFF);
        chk("drop_level",  64'(level), 64'd0);
        chk("drop_valid",  64'(bus.out_valid), 64'd0);

        // Simultaneous push/pop at level 1
        drive(1'b1, 2'b00, 32'h00000A5A, 3'b000);
        tick();
        log_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'(i % 3), 32'h1000 + 32'(i), 3'b111);
            tick();
            chk("pp_level", 64'(level), 64'd1);
        end
        log_en = 1'b0;
        chk("pp_count", 64'(emerged.size()), 64'd20);
        for (int j = 0; j < 20 && j < emerged.size(); j++) begin
            logic [34:0] exp_w;
            if (j == 0) exp_w = {3'b001, 32'h00000A5A};
            else        exp_w = {3'b001 << ((j - 1) % 3), 32'h1000 + 32'(j - 1)};
            chk("pp_order", 64'(emerged[j]), 64'(exp_w));
        end
        drive(1'b0, 2'b00, 32'h0, 3'b111);
        tick();

        // Reset mid-operation
        drive(1'b1, 2'b00, 32'h11111111, 3'b000);
        tick();
        drive(1'b1, 2'b01, 32'h22222222, 3'b000);
        tick();
        chk("pre_rst_level", 64'(level), 64'd2);
        reset = 1'b1;
        drive(1'b1, 2'b10, 32'h33333333, 3'b000);
        tick();
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_drop",  64'(drop_cnt), 64'd0);
        chk("mid_rst_data",  64'(bus.out_data), 64'd0);
        reset = 1'b0;
        drive(1'b1, 2'b10, 32'hCAFEF00D, 3'b111);
        #1;
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("after_rst_valid", 64'(bus.out_valid), 64'h4);
        chk("after_rst_data",  64'(bus.out_data), 64'hCAFEF00D);
        drive(1'b0, 2'b00, 32'h0, 3'b111);
        tick();
        chk("after_rst_level", 64'(level), 64'd0);
        tick();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_demux3.md
WB_DEMUX3 -- requirements
Module: wb_demux3

Interface
REQ-001 Parameter DATA_W, default 32: width of the data path.
REQ-002 Parameter DEPTH, default 2: number of entries in the internal buffer; legal values are 2 or 4.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the upstream producer offers a word.
REQ-006 Port in_ready, output, 1: the block can accept a word this cycle.
REQ-007 Port in_sel, input, 2: destination select; 2'b00, 2'b01 and 2'b10 are legal, 2'b11 is illegal.
REQ-008 Port in_data, input, DATA_W: the payload.
REQ-009 Port out_valid, output, 3: one-hot valid; bit k means the head word is addressed to destination k.
REQ-010 Port out_ready, input, 3: per-destination ready.
REQ-011 Port out_data, output, DATA_W: head payload, shared by all destinations.
REQ-012 Port drop_cnt, output, 8: saturating count of words dropped because in_sel was illegal.
REQ-013 Port level, output, 3: current buffer occupancy, from 0 to DEPTH.

Function
REQ-014 The block SHALL route each accepted word to exactly one destination. It is the inverse of the 3:1 writeback select: one source fanned out to three consumers.
REQ-015 An input transfer SHALL occur in a cycle where in_valid=1 and in_ready=1.
REQ-016 An output transfer SHALL occur in a cycle where out_valid[k]=1 and out_ready[k]=1.
REQ-017 in_ready SHALL equal (level < DEPTH). It is decoded from registered state only and SHALL NOT depend on out_ready in the same cycle.
REQ-018 An accepted word with a legal in_sel SHALL be written into a circular buffer as {sel, data}. It is written at the write pointer, and the write pointer then advances modulo DEPTH.
REQ-019 An accepted word with in_sel=2'b11 SHALL NOT be written into the buffer. drop_cnt SHALL increment by 1 and saturate at 8'hFF.
REQ-020 When level>0, out_valid SHALL be one-hot at bit head.sel, and out_data SHALL equal head.data.
REQ-021 When level==0, out_valid SHALL be 3'b000 and out_data SHALL hold its last value.
REQ-022 out_ready bits other than head.sel SHALL be ignored.
REQ-023 An output transfer SHALL pop the head, and the read pointer SHALL advance modulo DEPTH.
REQ-024 Latency: a word accepted in cycle N SHALL first appear on the outputs in cycle N+1, and no earlier.
REQ-025 When a legal push and a pop happen in the same cycle, level SHALL be unchanged and both pointers SHALL advance.
REQ-026 level SHALL change as follows:
  - +1 on a legal push with no pop;
  - -1 on a pop with no legal push;
  - unchanged otherwise.
REQ-027 Words SHALL leave in strict acceptance order, regardless of destination; there is no reordering and no bypass.
REQ-028 A head word whose destination is stalled SHALL block all younger words (head-of-line blocking is intended).
REQ-029 The pointers SHALL be log2(DEPTH) bits wide. Full and empty SHALL be derived from level, not from pointer equality.
REQ-030 out_valid[k], once asserted, SHALL remain asserted with a stable out_data until the word is popped or reset is asserted.

Reset
REQ-031 While reset=1 at a rising edge, the following SHALL be cleared on that edge:
  - the pointers, level and drop_cnt SHALL be set to 0;
  - out_valid SHALL be set to 3'b000;
  - out_data SHALL be set to 0.
REQ-032 While reset=1, in_ready SHALL be 0. In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered words without any output transfer. No partial word SHALL be presented afterwards.
REQ-034 Buffer storage contents need not be cleared by reset.

Verification
REQ-035 Single word: push {sel=01, data=32'hDEADBEEF} with out_ready=3'b111 -> in the next cycle out_valid=3'b010, out_data=32'hDEADBEEF; level goes 0->1->0.
REQ-036 Fill and stall (DEPTH=2): out_ready=0; push A (sel=00), then B (sel=10), then offer C -> level=2 and in_ready=0; C is not accepted; out_valid=3'b001 holds stable with data A for 10 cycles.
REQ-037 Drain order: continue from REQ-036 and raise only out_ready[2] -> nothing pops, because head A targets destination 0. Then raise out_ready[0] -> A pops, then B presents with out_valid=3'b100. C is accepted in the cycle after the A pop.
REQ-038 Illegal select: push 300 words with in_sel=11 -> level stays 0, out_valid stays 0, drop_cnt=8'hFF (saturated).
REQ-039 Simultaneous push/pop: level=1 with out_ready=3'b111 and continuous legal pushes over 20 cycles -> level stays 1 every cycle, and all 20 words emerge in order with their correct one-hot destinations.
REQ-040 Reset mid-operation: level=2, then assert reset for 1 cycle -> in the next cycle level=0, out_valid=0 and drop_cnt=0. A word pushed after reset emerges at N+1 uncorrupted.
